// File: rtl/user_obi_copy_mgr_pkg.sv
// OBI manager payload types for the user-domain copy engine.
package user_obi_copy_mgr_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned BeWidth   = 4;
  localparam int unsigned AidWidth  = 1;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [BeWidth-1:0]   be;
    logic [DataWidth-1:0] wdata;
    logic [AidWidth-1:0]  aid;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    logic            req;
    mgr_obi_a_chan_t a;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;

endpackage

// File: rtl/user_obi_copy_mgr_if.sv
// OBI manager port bundle; master drives requests, slave returns responses.
interface user_obi_copy_mgr_if;
  import user_obi_copy_mgr_pkg::*;

  mgr_obi_req_t obi_req_o;
  mgr_obi_rsp_t obi_rsp_i;

  modport master (output obi_req_o, input obi_rsp_i);
  modport slave  (input obi_req_o, output obi_rsp_i);
endinterface

// File: rtl/user_obi_copy_mgr.sv
// Word-by-word OBI block copy: read source word, write it to destination,
// one outstanding transaction at a time.
module user_obi_copy_mgr
  import user_obi_copy_mgr_pkg::*;
#(
  parameter int unsigned LenWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] src_addr_i,
  input  logic [AddrWidth-1:0] dst_addr_i,
  input  logic [LenWidth-1:0]  len_i,
  user_obi_copy_mgr_if.master  obi,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [LenWidth-1:0]  count_o
);

  localparam logic [AddrWidth-1:0] WordMask = AddrWidth'(32'hFFFF_FFFC);
  localparam logic [AddrWidth-1:0] WordStep = AddrWidth'(4);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_RSP = 3'd2,
    WR_REQ = 3'd3,
    WR_RSP = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] src_q, src_d;
  logic [AddrWidth-1:0] dst_q, dst_d;
  logic [LenWidth-1:0]  rem_q, rem_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [LenWidth-1:0]  count_q, count_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // State register; reset abandons any copy in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      count_q <= count_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state and datapath updates; responses outside *_RSP are dropped.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    count_d = count_q;
    err_d   = err_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = src_addr_i & WordMask;
          dst_d   = dst_addr_i & WordMask;
          rem_d   = len_i;
          count_d = '0;
          err_d   = 1'b0;
          if (len_i != '0) begin
            state_d = RD_REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD_REQ: begin
        if (obi.obi_rsp_i.gnt) state_d = RD_RSP;
      end
      RD_RSP: begin
        if (obi.obi_rsp_i.rvalid) begin
          if (obi.obi_rsp_i.r.err) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            data_d  = obi.obi_rsp_i.r.rdata;
            state_d = WR_REQ;
          end
        end
      end
      WR_REQ: begin
        if (obi.obi_rsp_i.gnt) state_d = WR_RSP;
      end
      WR_RSP: begin
        if (obi.obi_rsp_i.rvalid) begin
          if (obi.obi_rsp_i.r.err) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            count_d = count_q + LenWidth'(1);
            src_d   = src_q + WordStep;
            dst_d   = dst_q + WordStep;
            rem_d   = rem_q - LenWidth'(1);
            if (rem_q == LenWidth'(1)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = RD_REQ;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // A-channel decoded from state and registers only, so it holds while stalled.
  always_comb begin
    obi.obi_req_o = '0;
    unique case (state_q)
      RD_REQ: begin
        obi.obi_req_o.req    = 1'b1;
        obi.obi_req_o.a.addr = src_q;
        obi.obi_req_o.a.be   = BeWidth'(4'hF);
      end
      WR_REQ: begin
        obi.obi_req_o.req     = 1'b1;
        obi.obi_req_o.a.we    = 1'b1;
        obi.obi_req_o.a.addr  = dst_q;
        obi.obi_req_o.a.be    = BeWidth'(4'hF);
        obi.obi_req_o.a.wdata = data_q;
      end
      default: obi.obi_req_o = '0;
    endcase
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_user_obi_copy_mgr.sv
// Scoreboard bench: expected reads/writes queued at start, checked by the memory responder.
module tb_user_obi_copy_mgr;
  import user_obi_copy_mgr_pkg::*;

  localparam int unsigned LenWidth = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [31:0]         src;
  logic [31:0]         dst;
  logic [LenWidth-1:0] len;
  logic                busy;
  logic                done;
  logic                err;
  logic [LenWidth-1:0] count;

  user_obi_copy_mgr_if bus ();

  user_obi_copy_mgr #(.LenWidth(LenWidth)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .src_addr_i(src),
    .dst_addr_i(dst),
    .len_i     (len),
    .obi       (bus.master),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err),
    .count_o   (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  wr_exp_t     exp_wr_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] mem [logic [31:0]];

  int n_cmp = 0;
  int n_err = 0;

  int stall_max    = 0;
  int resp_max     = 0;
  bit hold_gnt     = 1'b0;
  bit stray_rvalid = 1'b0;
  int rd_count     = 0;
  int err_read_idx = -1;
  int done_cnt     = 0;
  int req_cyc      = 0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: random grant stalls, optional late rvalid, scoreboard pops.
  bit           rsp_pend = 1'b0;
  bit           in_req   = 1'b0;
  int           stall    = 0;
  int           rsp_wait = 0;
  logic [31:0]  rsp_data;
  logic         rsp_err;
  mgr_obi_req_t a_hold;
  mgr_obi_rsp_t r;
  wr_exp_t      we_exp;

  always @(negedge clk) begin
    r = '0;
    if (rst) begin
      rsp_pend = 1'b0;
      in_req   = 1'b0;
      stall    = 0;
    end else begin
      if (done) done_cnt++;
      if (bus.obi_req_o.req) req_cyc++;
      if (rsp_pend) begin
        if (rsp_wait > 0) begin
          rsp_wait--;
        end else begin
          r.rvalid  = 1'b1;
          r.r.rdata = rsp_data;
          r.r.err   = rsp_err;
          rsp_pend  = 1'b0;
        end
      end else if (bus.obi_req_o.req) begin
        if (!in_req) begin
          in_req = 1'b1;
          a_hold = bus.obi_req_o;
          stall  = int'($urandom_range(stall_max, 0));
        end else begin
          check_eq("a_stable", 96'(bus.obi_req_o), 96'(a_hold));
        end
        if (stall > 0) begin
          stall--;
        end else if (!(hold_gnt && bus.obi_req_o.a.we)) begin
          r.gnt    = 1'b1;
          in_req   = 1'b0;
          rsp_pend = 1'b1;
          rsp_wait = int'($urandom_range(resp_max, 0));
          rsp_err  = 1'b0;
          rsp_data = $urandom;
          check_eq("be_aid", 96'({bus.obi_req_o.a.be, bus.obi_req_o.a.aid}), 96'({4'hF, 1'b0}));
          if (!bus.obi_req_o.a.we) begin
            rd_count++;
            if (exp_rd_q.size() == 0) check_eq("rd_unexpected", 1, 0);
            else check_eq("rd_addr", bus.obi_req_o.a.addr, exp_rd_q.pop_front());
            rsp_data = mem.exists(bus.obi_req_o.a.addr) ? mem[bus.obi_req_o.a.addr] : 32'h0;
            rsp_err  = (rd_count == err_read_idx);
          end else begin
            if (exp_wr_q.size() == 0) begin
              check_eq("wr_unexpected", 1, 0);
            end else begin
              we_exp = exp_wr_q.pop_front();
              check_eq("wr_addr", bus.obi_req_o.a.addr, we_exp.addr);
              check_eq("wr_data", bus.obi_req_o.a.wdata, we_exp.data);
            end
            mem[bus.obi_req_o.a.addr] = bus.obi_req_o.a.wdata;
          end
        end
      end
      if (stray_rvalid) begin
        r.rvalid  = 1'b1;
        r.r.rdata = 32'hBAD0_BAD0;
      end
    end
    bus.obi_rsp_i = r;
  end

  // Preload n_rd source words and queue the reads and the first n_wr writes.
  task automatic push_exp(input logic [31:0] s, input logic [31:0] d, input int n_rd, input int n_wr);
    logic [31:0] a;
    for (int i = 0; i < n_rd; i++) begin
      a = s + 32'(4 * i);
      if (!mem.exists(a)) mem[a] = $urandom;
      exp_rd_q.push_back(a);
      if (i < n_wr) exp_wr_q.push_back('{addr: d + 32'(4 * i), data: mem[a]});
    end
  endtask

  // Start a copy and return the cycle (edge-0 relative) in which done_o is seen.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int l,
                          input int restart_at, output int cyc, output logic busy1);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    src   = s;
    dst   = d;
    len   = LenWidth'(l);
    @(posedge clk);
    cyc   = 0;
    busy1 = 1'b0;
    while (cyc < 3000 && !seen) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        busy1 = busy;
      end
      if (restart_at != 0 && cyc == restart_at) begin
        start = 1'b1;
        src   = 32'h5000_0000;
        dst   = 32'h6000_0000;
        len   = LenWidth'(9);
      end else if (restart_at != 0 && cyc == restart_at + 1) begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    if (!seen) check_eq("done_timeout", 0, 1);
  endtask

  int   cyc;
  int   dc0;
  int   rc0;
  logic busy1;
  bit   found;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    src   = '0;
    dst   = '0;
    len   = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_req", 96'(bus.obi_req_o), 96'(0));
    check_eq("rst_status", {busy, done, err}, 3'b000);
    check_eq("rst_count", count, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single word, zero-wait memory.
    mem[32'h1000_0000] = 32'hDEAD_BEEF;
    push_exp(32'h1000_0000, 32'h1000_0100, 1, 1);
    dc0 = done_cnt;
    run_copy(32'h1000_0000, 32'h1000_0100, 1, 0, cyc, busy1);
    check_eq("single_done_cycle", cyc, 5);
    check_eq("single_busy_c1", busy1, 1);
    check_eq("single_busy_end", busy, 0);
    check_eq("single_count", count, 1);
    check_eq("single_err", err, 0);
    @(negedge clk);
    check_eq("single_done_pulses", done_cnt - dc0, 1);
    check_eq("single_mem", mem[32'h1000_0100], 32'hDEAD_BEEF);

    // Burst of 8 with grant stalls and late responses.
    stall_max = 3;
    resp_max  = 1;
    push_exp(32'h1000_1000, 32'h1000_2000, 8, 8);
    dc0 = done_cnt;
    run_copy(32'h1000_1000, 32'h1000_2000, 8, 0, cyc, busy1);
    check_eq("burst_count", count, 8);
    check_eq("burst_err", err, 0);
    @(negedge clk);
    check_eq("burst_done_pulses", done_cnt - dc0, 1);
    for (int i = 0; i < 8; i++)
      check_eq("burst_mem", mem[32'h1000_2000 + 32'(4 * i)], mem[32'h1000_1000 + 32'(4 * i)]);
    stall_max = 0;
    resp_max  = 0;

    // Read error on the third word.
    push_exp(32'h1000_3000, 32'h1000_4000, 3, 2);
    err_read_idx = rd_count + 3;
    dc0 = done_cnt;
    run_copy(32'h1000_3000, 32'h1000_4000, 5, 0, cyc, busy1);
    check_eq("rderr_err", err, 1);
    check_eq("rderr_count", count, 2);
    check_eq("rderr_busy", busy, 0);
    repeat (3) @(negedge clk);
    check_eq("rderr_done_pulses", done_cnt - dc0, 1);
    check_eq("rderr_req_idle", bus.obi_req_o.req, 0);
    check_eq("rderr_q_empty", exp_rd_q.size() + exp_wr_q.size(), 0);
    err_read_idx = -1;

    // Zero length, then a copy with an ignored restart.
    rc0 = req_cyc;
    dc0 = done_cnt;
    run_copy(32'h1000_5000, 32'h1000_5100, 0, 0, cyc, busy1);
    check_eq("zero_done_cycle", cyc, 1);
    check_eq("zero_busy_c1", busy1, 0);
    check_eq("zero_err_cleared", err, 0);
    @(negedge clk);
    check_eq("zero_no_req", req_cyc - rc0, 0);
    check_eq("zero_done_pulses", done_cnt - dc0, 1);
    push_exp(32'h1000_0200, 32'h1000_0300, 4, 4);
    dc0 = done_cnt;
    run_copy(32'h1000_0200, 32'h1000_0300, 4, 3, cyc, busy1);
    check_eq("restart_done_cycle", cyc, 17);
    check_eq("restart_count", count, 4);
    repeat (3) @(negedge clk);
    check_eq("restart_done_pulses", done_cnt - dc0, 1);
    check_eq("restart_busy", busy, 0);

    // Source address wraps past the top of the address space.
    push_exp(32'hFFFF_FFF8, 32'h1000_5000, 3, 3);
    run_copy(32'hFFFF_FFF8, 32'h1000_5000, 3, 0, cyc, busy1);
    check_eq("wrap_done_cycle", cyc, 13);
    check_eq("wrap_count", count, 3);
    @(negedge clk);
    check_eq("wrap_q_empty", exp_rd_q.size() + exp_wr_q.size(), 0);

    // Reset while a write is waiting for grant, then a stray response.
    hold_gnt = 1'b1;
    push_exp(32'h1000_6000, 32'h1000_7000, 1, 0);
    @(negedge clk);
    start = 1'b1;
    src   = 32'h1000_6000;
    dst   = 32'h1000_7000;
    len   = LenWidth'(3);
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bus.obi_req_o.req && bus.obi_req_o.a.we) found = 1'b1;
    end
    check_eq("rstmid_wr_req_seen", found, 1);
    rst = 1'b1;
    #1;
    check_eq("rstmid_req", bus.obi_req_o.req, 0);
    check_eq("rstmid_busy", busy, 0);
    check_eq("rstmid_count", count, 0);
    @(negedge clk);
    rst      = 1'b0;
    hold_gnt = 1'b0;
    @(negedge clk);
    stray_rvalid = 1'b1;
    @(negedge clk);
    stray_rvalid = 1'b0;
    rc0 = req_cyc;
    repeat (2) @(negedge clk);
    check_eq("stray_ignored", {bus.obi_req_o.req, busy, done}, 3'b000);
    check_eq("stray_no_req", req_cyc - rc0, 0);
    push_exp(32'h1000_8000, 32'h1000_9000, 2, 2);
    run_copy(32'h1000_8000, 32'h1000_9000, 2, 0, cyc, busy1);
    check_eq("post_rst_done_cycle", cyc, 9);
    check_eq("post_rst_count", count, 2);
    check_eq("post_rst_err", err, 0);
    @(negedge clk);
    check_eq("final_q_empty", exp_rd_q.size() + exp_wr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

endmodule

// File: doc/user_obi_copy_mgr.md
# user_obi_copy_mgr

User-domain OBI manager that copies a block of 32-bit words from a source address to a destination address over the user manager port into the Croc crossbar. It drives `user_mgr_obi_req_o` / `user_mgr_obi_rsp_i` in `user_domain`, which is currently tied off. Typical use: moving audio sample buffers between SRAM and the audio filter subordinate without CPU load. Control is by a start strobe with base addresses and length. The block reports busy, done and error status.

## Interface

**Parameters**
- `LenWidth`, default 16: width of the word-count inputs and outputs.

**Ports**
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: reset; asynchronous, active-high.
- `start_i`, in, 1: start strobe. Sampled only in IDLE; ignored otherwise.
- `src_addr_i`, in, 32: source byte address. Captured on an accepted start; bits [1:0] are forced to 0.
- `dst_addr_i`, in, 32: destination byte address. Captured on an accepted start; bits [1:0] are forced to 0.
- `len_i`, in, `LenWidth`: number of words to copy. Captured on an accepted start.
- `obi_req_o`, out, `mgr_obi_req_t`: OBI A-channel. Fields `req`, `a.addr`, `a.we`, `a.be`, `a.wdata`, `a.aid`.
- `obi_rsp_i`, in, `mgr_obi_rsp_t`: OBI response. Fields `gnt`, `rvalid`, `r.rdata`, `r.err`.
- `busy_o`, out, 1: high from the cycle after an accepted start until the copy ends.
- `done_o`, out, 1: one-cycle pulse when a copy ends, whether by success or by error.
- `err_o`, out, 1: sticky error flag. Set on an error response; cleared on the next accepted start.
- `count_o`, out, `LenWidth`: number of words written successfully in the current or last copy.

## Operation

**State machine:** IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP.

- **IDLE**
  - `start_i`=1: latch source address, destination address, length and remaining count; clear `count_o` and `err_o`.
  - If `len_i`≠0, go to RD_REQ; if `len_i`=0, stay in IDLE and pulse `done_o` in the next cycle.
- **RD_REQ**
  - Outputs: `req`=1, `we`=0, `addr`=current source pointer, `be`=4'hF, `wdata`=0, `aid`=0.
  - On `gnt`: go to RD_RSP.
- **RD_RSP**
  - Outputs: `req`=0.
  - On `rvalid` with `err`=0: latch `rdata`, go to WR_REQ.
  - On `rvalid` with `err`=1: set `err_o`, go to IDLE, pulse `done_o`.
- **WR_REQ**
  - Outputs: `req`=1, `we`=1, `addr`=current destination pointer, `be`=4'hF, `wdata`=latched data, `aid`=0.
  - On `gnt`: go to WR_RSP.
- **WR_RSP**
  - On `rvalid` with `err`=0: increment `count_o`; add 4 to the source and destination pointers; decrement the remaining count. If the remaining count reaches 0, go to IDLE and pulse `done_o`; otherwise go to RD_REQ.
  - On `rvalid` with `err`=1: set `err_o`, do not increment `count_o`, go to IDLE, pulse `done_o`.

**OBI and arithmetic rules**
- At most one outstanding transaction at any time.
- While `req`=1 and `gnt`=0, `req` and all A-channel fields hold stable.
- `rvalid` in IDLE, RD_REQ or WR_REQ is ignored. This covers stale responses after a reset.
- Address increments wrap modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- `count_o` never exceeds the latched length.

## Timing

- **Reset values:** `req`=0, `a`=0, `busy_o`=0, `done_o`=0, `err_o`=0, `count_o`=0, state IDLE.
- **Reset mid-copy:** returns immediately to the reset values. No further requests are issued.
- **Start latency:** `start_i` sampled at edge 0 gives `req`=1 and `busy_o`=1 in cycle 1.
- **Throughput with zero-wait memory** (`gnt` in the same cycle as `req`, `rvalid` one cycle later): 4 cycles per word.
  - For L words, `done_o`=1 and `busy_o`=0 in cycle 4L+1.
  - For `len_i`=0, `done_o` pulses in cycle 1 and `busy_o` stays 0.
- **Outputs:** `done_o` and `busy_o` are registered. `obi_req_o` is decoded from state and registers only; it has no combinational path from `obi_rsp_i`.
- **Wait states:** each cycle of `gnt`=0 or of a late `rvalid` adds exactly one cycle.

## Test plan

- **Single-word copy:** src=0x1000_0000 holding 0xDEADBEEF, dst=0x1000_0100, len=1, zero-wait memory → dst word reads 0xDEADBEEF; `done_o` pulses in cycle 5; `count_o`=1; `err_o`=0.
- **Burst with grant stalls:** len=8, random `gnt` delays of 0–3 cycles → all 8 words match; A-channel fields stable while `req`=1 and `gnt`=0; `count_o`=8; exactly one `done_o` pulse.
- **Read error on word 3:** len=5, `r.err`=1 on the third read response → no third write issued; `err_o`=1; `count_o`=2; `done_o` pulses once; `busy_o` falls.
- **Zero length and busy start:** len=0 → `done_o` in cycle 1 with no `req`. Then start a len=4 copy and pulse `start_i` again mid-copy → second start ignored; latched addresses unchanged; `count_o`=4.
- **Address wrap:** src=0xFFFF_FFF8, len=3 → read addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **Reset mid-copy:** assert `rst_i` during WR_REQ, then return an `rvalid` after release → `req`=0, `busy_o`=0, `count_o`=0; stray `rvalid` ignored; a subsequent len=2 copy completes correctly.
